// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: FSM states, Populous signature, row addresses and SGX slot shared by the loader
package rom_loader_pkg;

  typedef enum logic [1:0] {S_IDLE, S_READY, S_WAIT_ACK, S_FULL} state_t;

  localparam logic [15:0] POP_SIG0 = 16'h4F50;
  localparam logic [15:0] POP_SIG1 = 16'h5550;
  localparam logic [15:0] POP_SIG2 = 16'h4F4C;
  localparam logic [15:0] POP_SIG3 = 16'h5355;

  localparam logic [19:0] POP_ROW_A = 20'h1F2;
  localparam logic [19:0] POP_ROW_B = 20'h212;

  localparam logic [4:0] SGX_INDEX = 5'd2;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [15:0] swap_word(input logic [15:0] d);
    return {rev8(d[15:8]), rev8(d[7:0])};
  endfunction

endpackage

// File: rtl/rom_sig_check.sv
// rom_sig_check: tracks the Populous signature candidates for headerless and 512-byte-header images
module rom_sig_check
  import rom_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        accept,
  input  logic [23:0] addr,
  input  logic [15:0] data,
  input  logic        hdr512,
  output logic        populous
);

  logic [1:0]  cand;
  logic [15:0] sig;
  logic        hit;

  // Expected signature word for this offset; only rows 0x1F2/0x212 at even offsets 6..12 are checked
  always_comb begin
    sig = addr[3:0] == 4'd6 ? POP_SIG0 :
          addr[3:0] == 4'd8 ? POP_SIG1 :
          addr[3:0] == 4'd10 ? POP_SIG2 : POP_SIG3;
    hit = (addr[23:4] == POP_ROW_A || addr[23:4] == POP_ROW_B) &&
          (addr[3:0] inside {4'd6, 4'd8, 4'd10, 4'd12});
  end

  // Both candidates start hopeful; a mismatching word rules out the header mode selected by bit 13
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cand <= 2'b00;
    else if (start) cand <= 2'b11;
    else if (accept && hit && data != sig) cand[addr[13]] <= 1'b0;
  end

  assign populous = cand[hdr512];

endmodule

// File: rtl/rom_loader.sv
// rom_loader: streams download words to SDRAM and DDR3 with a toggle handshake and back-pressure
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic [4:0]        dl_index,
  input  logic              dl_wr,
  input  logic [15:0]       dl_data,
  input  logic              swap_en,
  output logic              dl_wait,
  output logic              wr_req,
  input  logic              wr_ack_sd,
  input  logic              wr_ack_dd,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [7:0]        rom_size,
  output logic              hdr512,
  output logic              populous,
  output logic              sgx,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {{(ADDR_W-1){1'b1}}, 1'b0};

  state_t            state, state_n;
  logic              dl_active_q;
  logic              dl_wait_n, wr_req_n, sgx_n, overrun_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [15:0]       wr_data_n, data_sw;
  logic [23:0]       addr24;
  logic              acked, start, accept;

  generate
    if (ADDR_W >= 24) begin : g_wide
      assign addr24 = wr_addr[23:0];
    end else begin : g_narrow
      assign addr24 = {{(24-ADDR_W){1'b0}}, wr_addr};
    end
  endgenerate

  assign data_sw  = swap_en ? swap_word(dl_data) : dl_data;
  assign acked    = (wr_ack_sd == wr_req) && (wr_ack_dd == wr_req);
  assign rom_size = addr24[23:16];
  assign hdr512   = addr24[9];

  // State and datapath registers, plus the dl_active delay used for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      dl_active_q <= 1'b0;
      dl_wait     <= 1'b0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      sgx         <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      dl_active_q <= dl_active;
      dl_wait     <= dl_wait_n;
      wr_req      <= wr_req_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      sgx         <= sgx_n;
      overrun     <= overrun_n;
    end
  end

  // Next state: accept a word, wait for both controllers, then advance or stop at the top address
  always_comb begin
    state_n   = state;
    dl_wait_n = dl_wait;
    wr_req_n  = wr_req;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    sgx_n     = sgx;
    overrun_n = overrun;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (dl_active && !dl_active_q) begin
        state_n   = S_READY;
        wr_addr_n = '0;
        overrun_n = 1'b0;
        sgx_n     = dl_index == SGX_INDEX;
        start     = 1'b1;
      end
      S_READY: if (dl_wr) begin
        wr_data_n = data_sw;
        wr_req_n  = ~wr_req;
        dl_wait_n = 1'b1;
        accept    = 1'b1;
        state_n   = S_WAIT_ACK;
      end else if (!dl_active) state_n = S_IDLE;
      S_WAIT_ACK: begin
        if (dl_wr) overrun_n = 1'b1;
        if (acked) begin
          dl_wait_n = 1'b0;
          if (wr_addr == ADDR_LAST) state_n = S_FULL;
          else begin
            wr_addr_n = wr_addr + ADDR_W'(2);
            state_n   = dl_active ? S_READY : S_IDLE;
          end
        end
      end
      default: begin
        dl_wait_n = 1'b0;
        if (dl_wr) overrun_n = 1'b1;
        if (!dl_active) state_n = S_IDLE;
      end
    endcase
  end

  rom_sig_check u_sig (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .start    (start),
    .accept   (accept),
    .addr     (addr24),
    .data     (data_sw),
    .hdr512   (hdr512),
    .populous (populous)
  );

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ADDR_W, default 24, byte-address width of the ROM write port.
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 dl_active  in  1  cart download in progress; level.
REQ-005 dl_index  in  5  download slot index; sampled on the rising edge of dl_active.
REQ-006 dl_wr  in  1  one-cycle strobe qualifying dl_data.
REQ-007 dl_data  in  16  little-endian ROM word.
REQ-008 swap_en  in  1  bit-reverse each byte of dl_data ("ROM Data Swap").
REQ-009 dl_wait  out  1  back-pressure to the download source.
REQ-010 wr_req  out  1  toggle request to both memory controllers.
REQ-011 wr_ack_sd, wr_ack_dd  in  1 each  toggle acknowledges from SDRAM and DDR3 controllers.
REQ-012 wr_addr  out  ADDR_W  byte address of the current word.
REQ-013 wr_data  out  16  possibly swapped word.
REQ-014 rom_size  out  8  wr_addr[23:16] (64 KiB units).
REQ-015 hdr512  out  1  wr_addr[9]; 512-byte copier header present.
REQ-016 populous  out  1  Populous signature detected for the current header mode.
REQ-017 sgx  out  1  SuperGrafx image (dl_index==2).
REQ-018 overrun  out  1  sticky; dl_wr arrived while busy or address full.

Function
REQ-019 States: IDLE, READY, WAIT_ACK, FULL.
REQ-020 IDLE->READY on dl_active rising edge; same cycle clear wr_addr, overrun; set both populous candidates to 1; latch sgx.
REQ-021 READY, dl_wr=1: latch wr_data, toggle wr_req, assert dl_wait, go WAIT_ACK.
REQ-022 WAIT_ACK: remain until wr_ack_sd==wr_req and wr_ack_dd==wr_req; then deassert dl_wait and add 2 to wr_addr in the same cycle.
REQ-023 From WAIT_ACK, go READY if dl_active=1, else IDLE.
REQ-024 dl_data to wr_req latency exactly 1 cycle; dl_wait is registered and high from that same edge.
REQ-025 Swap: wr_data = {rev8(dl_data[15:8]), rev8(dl_data[7:0])} when swap_en=1, else dl_data.
REQ-026 Populous check on each accepted word whose wr_addr[23:4] is 0x1F2 or 0x212.
REQ-027 At offsets 6/8/10/12 compare against 0x4F50/0x5550/0x4F4C/0x5355; on mismatch clear candidate[wr_addr[13]].
REQ-028 The comparison uses the post-swap data.
REQ-029 populous = candidate[hdr512].
REQ-030 Address advance past 2^ADDR_W-2 enters FULL instead of wrapping; FULL holds dl_wait=0 and drops further dl_wr with overrun=1; FULL->IDLE on dl_active=0.
REQ-031 dl_wr in WAIT_ACK is dropped and sets overrun; in IDLE it is ignored.
REQ-032 dl_active falling in WAIT_ACK: the pending write completes before IDLE.
REQ-033 rom_size, hdr512, populous, sgx hold their values in IDLE until the next download starts.

Reset
REQ-034 reset_n=0: state IDLE, dl_wait=0, wr_req=0, wr_addr=0, wr_data=0, sgx=0, overrun=0, both candidates=0.
REQ-035 Reset mid-WAIT_ACK abandons the write; wr_req returns to 0, so the controllers must share this reset.

Structure
REQ-036 Shared package holds: the state enum, Populous signature words, signature row addresses 0x1F2/0x212, SGX index value 2.
REQ-037 One sub-module, rom_sig_check, implements REQ-026..REQ-029.
REQ-038 Otherwise a single clock domain with no memories.

Verification
REQ-039 Directed scenarios:
- Send 4 words 0x1234 with swap_en=0 and immediate acks -> wr_addr 0,2,4,6; wr_req toggles 4 times; dl_wait high 1 cycle beyond each ack.
- swap_en=1, dl_data=0x0180 -> wr_data=0x8001.
- Image with 512-byte header plus "POPULOUS" at byte 0x2126 -> hdr512=1, populous=1; altering one byte -> populous=0.
- wr_ack_dd delayed 20 cycles, plus a dl_wr during the wait -> single write, overrun=1, address advances once.
- reset_n low during WAIT_ACK, then a new download -> outputs per REQ-034, first address 0.
- ADDR_W=4, send 9 words -> FULL after 8; 9th dropped, overrun=1.
